// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the clock monitor.
package clock_monitor_pkg;

  // Widest phase counter the tolerance helper supports.
  localparam int unsigned MAX_CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SYNC      = 3'd1,
    MEAS_HIGH = 3'd2,
    MEAS_LOW  = 3'd3,
    STUCK     = 3'd4
  } state_e;

  // True when |cnt - exp_cyc| <= tol; one extra bit keeps the difference from wrapping.
  function automatic logic in_tol(input logic [MAX_CNT_W-1:0] cnt,
                                  input logic [MAX_CNT_W-1:0] exp_cyc,
                                  input logic [MAX_CNT_W-1:0] tol);
    logic signed [MAX_CNT_W:0] diff;
    diff = $signed({1'b0, cnt}) - $signed({1'b0, exp_cyc});
    if (diff < 0) diff = -diff;
    return (diff <= $signed({1'b0, tol}));
  endfunction

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Two-flop synchronizer for the monitored clock plus registered edge strobes.
module sync_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic D,
  output logic Rise,
  output logic Fall
);

  logic       sync1_q;
  logic       sync2_q;
  logic       dly_q;
  logic [2:0] vld_q;
  logic       rise_q;
  logic       fall_q;

  // vld_q gates the strobes until the delay flop holds a real sample, so a
  // clock that is high when reset releases does not produce a false edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      vld_q   <= 3'b000;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= D;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      vld_q   <= {vld_q[1:0], 1'b1};
      rise_q  <= vld_q[2] & sync2_q & ~dly_q;
      fall_q  <= vld_q[2] & ~sync2_q & dly_q;
    end
  end

  assign Rise = rise_q;
  assign Fall = fall_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures high/low phase lengths of MonClk in Clk cycles, flags errors,
// stuck clocks and lock.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned HIGH_CYC = 10,
  parameter int unsigned LOW_CYC  = 10,
  parameter int unsigned TOL      = 1,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned LOCK_N   = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             MonClk,
  input  logic             ClrErr,
  output logic [CNT_W-1:0] HighCnt,
  output logic [CNT_W-1:0] LowCnt,
  output logic             MeasValid,
  output logic             ErrHigh,
  output logic             ErrLow,
  output logic             Stuck,
  output logic             Locked
);

  localparam int unsigned      GOOD_W  = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rise;
  logic fall;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               high_ok_q, high_ok_d;
  logic [CNT_W-1:0]   high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]   low_cnt_q, low_cnt_d;
  logic               meas_valid_q, meas_valid_d;
  logic               err_high_q, err_high_d;
  logic               err_low_q, err_low_d;
  logic               stuck_q, stuck_d;
  logic               locked_q, locked_d;
  logic               high_in_tol_c;
  logic               low_in_tol_c;
  logic               timeout_c;

  sync_edge_detect u_sync (
    .Clk  (Clk),
    .Rst  (Rst),
    .D    (MonClk),
    .Rise (rise),
    .Fall (fall)
  );

  // A saturated counter never passes, whatever the tolerance.
  assign high_in_tol_c = (cnt_q != CNT_MAX) &&
                         in_tol(MAX_CNT_W'(cnt_q), MAX_CNT_W'(HIGH_CYC), MAX_CNT_W'(TOL));
  assign low_in_tol_c  = (cnt_q != CNT_MAX) &&
                         in_tol(MAX_CNT_W'(cnt_q), MAX_CNT_W'(LOW_CYC), MAX_CNT_W'(TOL));
  assign timeout_c     = (cnt_q == CNT_W'(TIMEOUT));

  // Next-state, counter and flag logic.
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    high_ok_d    = high_ok_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    meas_valid_d = 1'b0;
    err_high_d   = ClrErr ? 1'b0 : err_high_q;
    err_low_d    = ClrErr ? 1'b0 : err_low_q;
    stuck_d      = stuck_q;
    locked_d     = locked_q;

    if (rise || fall)          cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    else                       cnt_d = cnt_q;

    if (!En) begin
      // Disable beats any edge in the same cycle: no capture.
      state_d   = IDLE;
      cnt_d     = '0;
      good_d    = '0;
      high_ok_d = 1'b0;
      stuck_d   = 1'b0;
      locked_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = SYNC;
        end
        SYNC, STUCK: begin
          // Re-align on the next edge; the partial phase is discarded.
          if (rise) begin
            state_d   = MEAS_HIGH;
            high_ok_d = 1'b0;
            stuck_d   = 1'b0;
          end else if (fall) begin
            state_d   = MEAS_LOW;
            high_ok_d = 1'b0;
            stuck_d   = 1'b0;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_cnt_d = cnt_q;
            high_ok_d  = high_in_tol_c;
            if (!high_in_tol_c) begin
              err_high_d = 1'b1;
              good_d     = '0;
              locked_d   = 1'b0;
            end
            state_d = MEAS_LOW;
          end else if (!rise && timeout_c) begin
            state_d  = STUCK;
            stuck_d  = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            low_cnt_d    = cnt_q;
            meas_valid_d = 1'b1;
            if (!low_in_tol_c) begin
              err_low_d = 1'b1;
              good_d    = '0;
              locked_d  = 1'b0;
            end else if (high_ok_q) begin
              if (good_q != GOOD_W'(LOCK_N)) good_d = good_q + GOOD_W'(1);
              if (good_d == GOOD_W'(LOCK_N)) locked_d = 1'b1;
            end
            high_ok_d = 1'b0;
            state_d   = MEAS_HIGH;
          end else if (!fall && timeout_c) begin
            state_d  = STUCK;
            stuck_d  = 1'b1;
            good_d   = '0;
            locked_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      good_q       <= '0;
      high_ok_q    <= 1'b0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      meas_valid_q <= 1'b0;
      err_high_q   <= 1'b0;
      err_low_q    <= 1'b0;
      stuck_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      high_ok_q    <= high_ok_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      meas_valid_q <= meas_valid_d;
      err_high_q   <= err_high_d;
      err_low_q    <= err_low_d;
      stuck_q      <= stuck_d;
      locked_q     <= locked_d;
    end
  end

  assign HighCnt   = high_cnt_q;
  assign LowCnt    = low_cnt_q;
  assign MeasValid = meas_valid_q;
  assign ErrHigh   = err_high_q;
  assign ErrLow    = err_low_q;
  assign Stuck     = stuck_q;
  assign Locked    = locked_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor; measured periods are scoreboarded.
module tb_clock_monitor;

  localparam int unsigned CNT_W = 16;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             En;
  logic             MonClk;
  logic             ClrErr;
  logic [CNT_W-1:0] HighCnt;
  logic [CNT_W-1:0] LowCnt;
  logic             MeasValid;
  logic             ErrHigh;
  logic             ErrLow;
  logic             Stuck;
  logic             Locked;

  int passed = 0;
  int total  = 0;
  int exp_hi_q[$];
  int exp_lo_q[$];

  clock_monitor dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .En        (En),
    .MonClk    (MonClk),
    .ClrErr    (ClrErr),
    .HighCnt   (HighCnt),
    .LowCnt    (LowCnt),
    .MeasValid (MeasValid),
    .ErrHigh   (ErrHigh),
    .ErrLow    (ErrLow),
    .Stuck     (Stuck),
    .Locked    (Locked)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hcnt"},  32'(HighCnt), 0);
    check({tag, "_lcnt"},  32'(LowCnt), 0);
    check({tag, "_mv"},    32'(MeasValid), 0);
    check({tag, "_errh"},  32'(ErrHigh), 0);
    check({tag, "_errl"},  32'(ErrLow), 0);
    check({tag, "_stuck"}, 32'(Stuck), 0);
    check({tag, "_lock"},  32'(Locked), 0);
  endtask

  task automatic high(input int n);
    MonClk = 1'b1;
    repeat (n) @(negedge Clk);
  endtask

  task automatic low(input int n);
    MonClk = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic push(input int hi, input int lo);
    exp_hi_q.push_back(hi);
    exp_lo_q.push_back(lo);
  endtask

  task automatic period(input int ton, input int toff);
    push(ton, toff);
    high(ton);
    low(toff);
  endtask

  // Scoreboard: every MeasValid pulse must match the oldest expected period.
  always @(negedge Clk) begin
    if (!Rst && MeasValid) begin
      if (exp_hi_q.size() == 0) begin
        check("unexpected_measvalid", 32'(MeasValid), 0);
      end else begin
        int eh;
        int el;
        eh = exp_hi_q.pop_front();
        el = exp_lo_q.pop_front();
        check("sb_highcnt", 32'(HighCnt), 32'(eh));
        check("sb_lowcnt",  32'(LowCnt),  32'(el));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; En = 1'b0; MonClk = 1'b0; ClrErr = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check_all_zero("reset");

    // Nominal 10/10 clock: lock after the 4th measured period.
    En = 1'b1;
    low(5);
    for (int i = 0; i < 4; i++) period(10, 10);
    check("t1_lock_before", 32'(Locked), 0);
    push(10, 10);
    high(5);
    check("t1_lock_after", 32'(Locked), 1);
    check("t1_errh", 32'(ErrHigh), 0);
    check("t1_errl", 32'(ErrLow), 0);
    high(5);
    low(10);

    // Long high phase, clear and re-assert.
    push(14, 10);
    high(14);
    low(5);
    check("t2_errh_set", 32'(ErrHigh), 1);
    check("t2_errl", 32'(ErrLow), 0);
    check("t2_lock_drop", 32'(Locked), 0);
    check("t2_highcnt", 32'(HighCnt), 14);
    low(2);
    ClrErr = 1'b1;
    low(1);
    ClrErr = 1'b0;
    check("t2_errh_clr", 32'(ErrHigh), 0);
    low(2);
    push(14, 10);
    high(14);
    low(5);
    check("t2_errh_reset", 32'(ErrHigh), 1);
    check("t2_lock_stay0", 32'(Locked), 0);
    low(5);

    // Lock, then MonClk held high until Stuck.
    for (int i = 0; i < 4; i++) period(10, 10);
    high(5);
    check("t3_lock", 32'(Locked), 1);
    high(998);
    check("t3_stuck_early", 32'(Stuck), 0);
    high(1);
    check("t3_stuck_set", 32'(Stuck), 1);
    check("t3_lock_drop", 32'(Locked), 0);
    low(5);
    check("t3_stuck_clr", 32'(Stuck), 0);
    push(10, 10);
    low(5);
    for (int i = 0; i < 4; i++) period(10, 10);
    check("t3_relock_before", 32'(Locked), 0);
    high(5);
    check("t3_relock", 32'(Locked), 1);

    // Asynchronous reset in the middle of a high phase.
    check("t4_sb_empty", 32'(exp_hi_q.size()), 0);
    #2 Rst = 1'b1;
    #1 check_all_zero("t4_async");
    @(negedge Clk);
    Rst = 1'b0;
    high(4);
    low(5);
    check("t4_no_capture", 32'(HighCnt), 0);
    push(0, 10);
    low(5);
    for (int i = 0; i < 4; i++) period(10, 10);
    check("t4_lock_before", 32'(Locked), 0);
    high(5);
    check("t4_lock", 32'(Locked), 1);

    // Enable dropped for 50 cycles while locked.
    En = 1'b0;
    high(2);
    check("t5_lock_drop", 32'(Locked), 0);
    check("t5_hcnt_hold", 32'(HighCnt), 10);
    check("t5_lcnt_hold", 32'(LowCnt), 10);
    high(3); low(10); high(10); low(10); high(10); low(5);
    En = 1'b1;
    low(5);
    for (int i = 0; i < 4; i++) period(10, 10);
    check("t5_lock_before", 32'(Locked), 0);
    high(5);
    check("t5_relock", 32'(Locked), 1);

    // ClrErr coincides with an out-of-tolerance low capture.
    push(10, 3);
    high(5);
    low(3);
    check("t6_errl_before", 32'(ErrLow), 0);
    MonClk = 1'b1;
    repeat (3) @(negedge Clk);
    ClrErr = 1'b1;
    @(negedge Clk);
    ClrErr = 1'b0;
    check("t6_errl_wins", 32'(ErrLow), 1);
    check("t6_lock_drop", 32'(Locked), 0);
    high(20);
    check("end_sb_empty", 32'(exp_hi_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
